// File: rtl/tdm_demux_8ch.sv
// 8-channel serial TDM demultiplexer: locks to a frame sync on slot 0, collects
// slots 1..7 and publishes a parallel frame, flywheeling over a few missing syncs.
module tdm_demux_8ch #(
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       en,
  input  logic       sync,
  output logic [7:0] y,
  output logic       frame_valid,
  output logic [2:0] slot,
  output logic       locked,
  output logic       sync_err
);

  // Counter just wide enough to hold MISS_LIMIT (0..7) without wrapping.
  localparam int unsigned MW = (MISS_LIMIT > 3) ? 3 : ((MISS_LIMIT > 1) ? 2 : 1);
  localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    slot_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [6:0]    shadow_q, shadow_d;
  logic [7:0]    y_d;
  logic          fv_d;
  logic          err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot        <= '0;
      miss_q      <= '0;
      shadow_q    <= '0;
      y           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot        <= slot_d;
      miss_q      <= miss_d;
      shadow_q    <= shadow_d;
      y           <= y_d;
      frame_valid <= fv_d;
      sync_err    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot;
    miss_d   = miss_q;
    shadow_d = shadow_q;
    y_d      = y;
    fv_d     = 1'b0;
    err_d    = 1'b0;

    if (en) begin
      unique case (state_q)
        HUNT: begin
          slot_d = '0;
          if (sync) begin
            shadow_d[0] = din;
            slot_d      = 3'd1;
            miss_d      = '0;
            state_d     = LOCKED;
          end
        end

        LOCKED: begin
          if (sync) begin
            // A sync anywhere but slot 0 realigns; it outranks frame completion at slot 7.
            err_d       = (slot != 3'd0);
            shadow_d[0] = din;
            slot_d      = 3'd1;
            miss_d      = '0;
          end else if (slot == 3'd0) begin
            if (miss_q < MISS_MAX) begin
              miss_d      = miss_q + MW'(1);
              shadow_d[0] = din;
              slot_d      = 3'd1;
            end else begin
              err_d   = 1'b1;
              slot_d  = '0;
              state_d = HUNT;
            end
          end else if (slot == 3'd7) begin
            y_d    = {din, shadow_q};
            fv_d   = 1'b1;
            slot_d = '0;
          end else begin
            for (int unsigned i = 1; i < 7; i++) begin
              if (slot == 3'(i)) shadow_d[i] = din;
            end
            slot_d = slot + 3'd1;
          end
        end

        default: begin
          state_d = HUNT;
          slot_d  = '0;
        end
      endcase
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Table-driven bench for tdm_demux_8ch: per-cycle vectors plus hand-written
// sequences for asynchronous reset and post-reset resynchronisation.
module tb_tdm_demux_8ch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       en;
  logic       sync;
  logic [7:0] y;
  logic       frame_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  tdm_demux_8ch #(.MISS_LIMIT(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .en          (en),
    .sync        (sync),
    .y           (y),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       sync;
    logic       din;
    logic [7:0] y;
    logic       fv;
    logic [2:0] slot;
    logic       lk;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [7:0] ey, input logic efv,
                       input logic [2:0] eslot, input logic elk, input logic eerr);
    logic [13:0] act;
    logic [13:0] exp;
    act = {y, frame_valid, slot, locked, sync_err};
    exp = {ey, efv, eslot, elk, eerr};
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got y=%h fv=%b slot=%0d locked=%b err=%b, want y=%h fv=%b slot=%0d locked=%b err=%b",
               nm, y, frame_valid, slot, locked, sync_err, ey, efv, eslot, elk, eerr);
    else
      n_pass++;
  endtask

  task automatic push(input logic e, input logic s, input logic d, input logic [7:0] ey,
                      input logic efv, input logic [2:0] eslot, input logic elk, input logic eerr);
    vec_t v;
    v.en = e; v.sync = s; v.din = d; v.y = ey; v.fv = efv;
    v.slot = eslot; v.lk = elk; v.err = eerr;
    tbl.push_back(v);
  endtask

  // Full frame while locked; gaps insert en=0 cycles carrying a bogus sync and inverted din.
  task automatic push_frame(input logic [7:0] bits, input logic sync0, input int gaps,
                            input logic [7:0] y_before, input logic [7:0] y_after);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] ye;
      logic [2:0] es;
      ye = (k == 7) ? y_after : y_before;
      es = (k == 7) ? 3'd0 : 3'(k + 1);
      push(1'b1, (k == 0) ? sync0 : 1'b0, bits[k], ye, k == 7, es, 1'b1, 1'b0);
      for (int g = 0; g < gaps; g++)
        push(1'b0, 1'b1, ~bits[k], ye, 1'b0, es, 1'b1, 1'b0);
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), then check at the following negedge.
  task automatic step(input string nm, input logic e, input logic s, input logic d,
                      input logic [7:0] ey, input logic efv, input logic [2:0] eslot,
                      input logic elk, input logic eerr);
    en = e; sync = s; din = d;
    @(negedge clk);
    check(nm, ey, efv, eslot, elk, eerr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f8d;
    f8d = 8'h8D;

    // HUNT qualification: sync without en is ignored; en without sync is discarded.
    push(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    // Clean frame then the same frame with two idle cycles between slots.
    push_frame(8'h8D, 1'b1, 0, 8'h00, 8'h8D);
    push_frame(8'h8D, 1'b1, 2, 8'h8D, 8'h8D);
    // Misplaced sync at the fifth sample, then seven samples complete frame A6.
    push(1'b1, 1'b1, 1'b1, 8'h8D, 1'b0, 3'd1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1, 8'h8D, 1'b0, 3'd2, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1, 8'h8D, 1'b0, 3'd3, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1, 8'h8D, 1'b0, 3'd4, 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b0, 8'h8D, 1'b0, 3'd1, 1'b1, 1'b1);
    push(1'b1, 1'b0, 1'b1, 8'h8D, 1'b0, 3'd2, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1, 8'h8D, 1'b0, 3'd3, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b0, 8'h8D, 1'b0, 3'd4, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b0, 8'h8D, 1'b0, 3'd5, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1, 8'h8D, 1'b0, 3'd6, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b0, 8'h8D, 1'b0, 3'd7, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1, 8'hA6, 1'b1, 3'd0, 1'b1, 1'b0);
    // Sync arriving at slot 7 wins over frame completion; realigned frame gives 81.
    for (int k = 0; k < 7; k++)
      push(1'b1, k == 0, 1'b1, 8'hA6, 1'b0, 3'(k + 1), 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b1, 8'hA6, 1'b0, 3'd1, 1'b1, 1'b1);
    for (int k = 1; k < 7; k++)
      push(1'b1, 1'b0, 1'b0, 8'hA6, 1'b0, 3'(k + 1), 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 3'd0, 1'b1, 1'b0);
    // Flywheel: two sync-less frames accepted, third slot 0 drops lock.
    push_frame(8'h3C, 1'b0, 0, 8'h81, 8'h3C);
    push_frame(8'hC3, 1'b0, 0, 8'h3C, 8'hC3);
    push(1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 3'd0, 1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 3'd0, 1'b0, 1'b0);

    rst_n = 1'b0; en = 1'b0; sync = 1'b0; din = 1'b0;
    #3;
    check("reset_state", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      string nm;
      nm = $sformatf("vec[%0d]", i);
      step(nm, tbl[i].en, tbl[i].sync, tbl[i].din,
           tbl[i].y, tbl[i].fv, tbl[i].slot, tbl[i].lk, tbl[i].err);
    end

    // Reset mid-frame: relock, send slots 0..3, then assert reset between edges.
    step("rs_s0", 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 3'd1, 1'b1, 1'b0);
    step("rs_s1", 1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, 3'd2, 1'b1, 1'b0);
    step("rs_s2", 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 3'd3, 1'b1, 1'b0);
    step("rs_s3", 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 3'd4, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("reset_hold", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++)
      step($sformatf("post_rst_nosync[%0d]", k), 1'b1, 1'b0, k[0],
           8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      step($sformatf("post_rst_frame[%0d]", k), 1'b1, k == 0, f8d[k],
           (k == 7) ? 8'h8D : 8'h00, k == 7, (k == 7) ? 3'd0 : 3'(k + 1), 1'b1, 1'b0);
    step("idle_after", 1'b0, 1'b0, 1'b0, 8'h8D, 1'b0, 3'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
